// File: rtl/instr_fetch.sv
// MIPS instruction-fetch stage: owns the PC, drives a single-outstanding req/ack
// instruction port and loads the IF/ID register {instr, PC+4}.
module instr_fetch #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk_87,
    input  logic                   rst_87,
    output logic                   imem_req_87,
    output logic [ADDR_WIDTH-1:0]  imem_addr_87,
    input  logic                   imem_ack_87,
    input  logic [INSTR_WIDTH-1:0] imem_data_87,
    output logic [INSTR_WIDTH-1:0] instr_87,
    output logic [ADDR_WIDTH-1:0]  pc_out_87,
    input  logic                   stall_87,
    input  logic                   branch_flag_87,
    input  logic                   jump_flag_87,
    input  logic [ADDR_WIDTH-1:0]  target_pc_87,
    input  logic                   halt_87,
    output logic [31:0]            fetch_count_87
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t                 state_q;
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic [ADDR_WIDTH-1:0]  tgt_pend_q;
    logic [INSTR_WIDTH-1:0] hold_buf_q;
    logic                   halt_pend_q;
    logic                   req_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [ADDR_WIDTH-1:0]  pc_out_q;
    logic [31:0]            fetch_count_q;

    logic                   redirect_d;
    logic [ADDR_WIDTH-1:0]  pc_inc_d;

    assign redirect_d = branch_flag_87 | jump_flag_87;
    assign pc_inc_d   = pc_q + ADDR_WIDTH'(4);

    // The PC register doubles as the fetch address; it only moves on an ack or
    // when no request is outstanding, so the address stays stable until ack.
    assign imem_req_87    = req_q;
    assign imem_addr_87   = pc_q;
    assign instr_87       = instr_q;
    assign pc_out_87      = pc_out_q;
    assign fetch_count_87 = fetch_count_q;

    always_ff @(posedge clk_87 or posedge rst_87) begin
        if (rst_87) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            tgt_pend_q    <= '0;
            hold_buf_q    <= '0;
            halt_pend_q   <= 1'b0;
            req_q         <= 1'b0;
            instr_q       <= '0;
            pc_out_q      <= '0;
            fetch_count_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                end

                S_FETCH: begin
                    if (halt_87) begin
                        instr_q  <= '0;
                        pc_out_q <= '0;
                        if (imem_ack_87) begin
                            state_q <= S_HALTED;
                            req_q   <= 1'b0;
                        end else begin
                            halt_pend_q <= 1'b1;
                            state_q     <= S_DRAIN;
                        end
                    end else if (redirect_d) begin
                        instr_q  <= '0;
                        pc_out_q <= '0;
                        if (imem_ack_87) begin
                            pc_q <= target_pc_87;
                        end else begin
                            tgt_pend_q <= target_pc_87;
                            state_q    <= S_DRAIN;
                        end
                    end else if (stall_87) begin
                        if (imem_ack_87) begin
                            hold_buf_q <= imem_data_87;
                            req_q      <= 1'b0;
                            state_q    <= S_HOLD;
                        end
                    end else if (imem_ack_87) begin
                        instr_q       <= imem_data_87;
                        pc_out_q      <= pc_inc_d;
                        pc_q          <= pc_inc_d;
                        fetch_count_q <= fetch_count_q + 32'd1;
                    end else begin
                        instr_q  <= '0;
                        pc_out_q <= '0;
                    end
                end

                S_HOLD: begin
                    if (halt_87) begin
                        instr_q  <= '0;
                        pc_out_q <= '0;
                        state_q  <= S_HALTED;
                    end else if (redirect_d) begin
                        instr_q  <= '0;
                        pc_out_q <= '0;
                        pc_q     <= target_pc_87;
                        req_q    <= 1'b1;
                        state_q  <= S_FETCH;
                    end else if (!stall_87) begin
                        instr_q       <= hold_buf_q;
                        pc_out_q      <= pc_inc_d;
                        pc_q          <= pc_inc_d;
                        fetch_count_q <= fetch_count_q + 32'd1;
                        req_q         <= 1'b1;
                        state_q       <= S_FETCH;
                    end
                end

                S_DRAIN: begin
                    instr_q  <= '0;
                    pc_out_q <= '0;
                    // Halt or redirect arriving in the ack cycle still takes effect.
                    if (imem_ack_87) begin
                        if (halt_pend_q || halt_87) begin
                            req_q   <= 1'b0;
                            state_q <= S_HALTED;
                        end else begin
                            pc_q    <= redirect_d ? target_pc_87 : tgt_pend_q;
                            state_q <= S_FETCH;
                        end
                    end else begin
                        if (halt_87)    halt_pend_q <= 1'b1;
                        if (redirect_d) tgt_pend_q  <= target_pc_87;
                    end
                end

                S_HALTED: begin
                    req_q    <= 1'b0;
                    instr_q  <= '0;
                    pc_out_q <= '0;
                end

                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch (IF) stage of the 5-stage MIPS pipeline, directly upstream of the instruction-decode stage. It owns the program counter and drives a req/ack instruction-memory port with one request outstanding at a time. It loads the IF/ID pipeline register (instruction and PC+4), honours decode-stage stalls, redirects on branches and jumps, and stops fetching on system halt.

## Interface
Parameters:
- ADDR_WIDTH, 32, PC and memory address width
- INSTR_WIDTH, 32, instruction width
- RESET_PC, 0, first fetch address after reset

Ports:
- clk_87  in  1  clock; all state changes on posedge
- rst_87  in  1  reset; asynchronous, active-high
- imem_req_87  out  1  fetch request; registered
- imem_addr_87  out  ADDR_WIDTH  fetch address; stable while imem_req_87 is high until ack
- imem_ack_87  in  1  data valid on imem_data_87 this cycle; may arrive in the same cycle as the request
- imem_data_87  in  INSTR_WIDTH  fetched instruction
- instr_87  out  INSTR_WIDTH  IF/ID instruction; 0 is a NOP/bubble
- pc_out_87  out  ADDR_WIDTH  IF/ID PC+4 of instr_87; used by decode as the branch base
- stall_87  in  1  hold the IF/ID register and the PC
- branch_flag_87  in  1  branch taken in decode (combinational)
- jump_flag_87  in  1  jump taken in decode (combinational)
- target_pc_87  in  ADDR_WIDTH  redirect target; valid when redirect = branch_flag_87 | jump_flag_87
- halt_87  in  1  system halt from decode
- fetch_count_87  out  32  number of non-bubble instructions loaded into IF/ID

## Operation
- Registers: pc, state, hold_buf, tgt_pend, halt_pend, IF/ID {instr_87, pc_out_87}, fetch_count_87.
- Reset values: state=IDLE; pc=RESET_PC; imem_req_87=0; imem_addr_87=RESET_PC; instr_87=0; pc_out_87=0; fetch_count_87=0; pending flags=0.
- The priority order is halt > redirect > stall > normal.
- IDLE: always moves to FETCH on the next edge. imem_req_87 rises on that edge.
- FETCH (req=1, addr=pc):
  - halt: if ack, go to HALTED. If no ack, set halt_pend and go to DRAIN. IF/ID is set to 0.
  - redirect: IF/ID is set to 0. If ack, discard the data, set pc=target_pc_87 and stay in FETCH. If no ack, latch tgt_pend and go to DRAIN.
  - stall: IF/ID holds. If ack, set hold_buf=data, drop req and go to HOLD.
  - normal with ack: instr_87=data, pc_out_87=pc+4, pc=pc+4, fetch_count++.
  - normal without ack: IF/ID is set to 0 (bubble).
- HOLD (req=0):
  - halt: go to HALTED.
  - redirect: discard hold_buf, set pc=target, IF/ID=0, go to FETCH.
  - stall: hold.
  - otherwise: IF/ID={hold_buf, pc+4}, pc=pc+4, fetch_count++, go to FETCH.
- DRAIN: keep req and addr unchanged until ack. On ack, discard the data. Then go to HALTED if halt_pend; otherwise set pc=tgt_pend and go to FETCH. A newer redirect seen in DRAIN overwrites tgt_pend. A halt seen in DRAIN sets halt_pend. IF/ID=0 while in DRAIN.
- HALTED: req=0, IF/ID=0. Leaves only on reset.
- Arithmetic: pc+4 is modulo 2^ADDR_WIDTH, so 0xFFFFFFFC wraps to 0. fetch_count_87 wraps modulo 2^32.
- A write of 0 into IF/ID is a bubble and does not increment fetch_count_87. A fetched 0x00000000 word is a real NOP and does increment it.

## Timing
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle. The word at A appears on instr_87 after the edge that samples ack, with pc_out_87=A+4.
- First fetch: req=1 in cycle 1 after reset release. The first instruction is in IF/ID after edge 1 when memory is zero-wait.
- Redirect sampled at edge n:
  - The word fetched in cycle n is squashed.
  - The target is requested in cycle n+1.
  - The target instruction is in IF/ID after edge n+1 (zero-wait).
  - This gives one bubble.
- Stall: IF/ID and pc are frozen for exactly the stalled cycles. No instruction is lost or duplicated.
- Asynchronous reset mid-DRAIN or mid-HOLD: every register returns to its reset value immediately. Any in-flight ack after reset is ignored because state is IDLE.
- Redirect and stall in the same cycle: the redirect wins and IF/ID is set to 0.
- Halt and redirect in the same cycle: halt wins.

## Test plan
- Zero-wait memory where mem[A]=A+0x100: after reset, instr_87 shows 0x100, 0x104, 0x108 on consecutive cycles, with pc_out_87=4, 8, 12, and fetch_count_87=3.
- Memory with 2-cycle ack latency: a bubble (instr_87=0) appears between instructions, imem_addr_87 is held steady while waiting, and fetch_count_87 increments once per ack.
- stall_87 held for 3 cycles while an ack arrives: the FSM goes to HOLD with req=0, IF/ID is frozen, and on release the buffered word loads with pc_out_87 = its address+4 and nothing is skipped.
- branch_flag_87=1 with target_pc_87=0x40 while fetching 0x10 (zero-wait): IF/ID=0 next cycle, then instr_87=mem[0x40] with pc_out_87=0x44.
- Redirect to 0x80 during a 3-cycle-latency fetch of 0x20: the FSM goes to DRAIN, the 0x20 data is discarded, the next request is 0x80, and no mem[0x20] word reaches IF/ID.
- halt_87 pulsed: req drops after any outstanding ack, instr_87 stays 0 and fetch_count_87 stays frozen. Asserting rst_87 asynchronously mid-stream gives req=0 immediately and fetch restarts at RESET_PC.
